// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Brief    : Pipeline stage register with valid/ready handshake, two-entry
//            skid buffer, synchronous flush and PC-carrying bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int          DATA_W   = 96,
    parameter int          PC_W     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [PC_W-1:0]   flush_pc,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] c_empty = 2'd0;
    localparam logic [1:0] c_one   = 2'd1;
    localparam logic [1:0] c_full  = 2'd2;

    logic [1:0]        r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [PC_W-1:0]   r_main_pc;
    logic [DATA_W-1:0] r_main_data;
    logic [PC_W-1:0]   r_skid_pc;
    logic [DATA_W-1:0] r_skid_data;

    logic w_in_fire;
    logic w_out_fire;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_empty;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_pc   <= RESET_PC[PC_W-1:0];
            r_main_data <= '0;
            r_skid_pc   <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            // The bubble keeps the caller's PC so later stages can report EPC.
            r_state     <= c_empty;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_pc   <= flush_pc;
            r_main_data <= '0;
            r_skid_pc   <= '0;
            r_skid_data <= '0;
        end else begin
            case (r_state)
                c_empty: begin
                    if (w_in_fire) begin
                        r_main_pc   <= in_pc;
                        r_main_data <= in_data;
                        r_out_valid <= 1'b1;
                        r_state     <= c_one;
                    end
                end
                c_one: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_pc   <= in_pc;
                        r_main_data <= in_data;
                    end else if (w_in_fire) begin
                        r_skid_pc   <= in_pc;
                        r_skid_data <= in_data;
                        r_in_ready  <= 1'b0;
                        r_state     <= c_full;
                    end else if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_empty;
                    end
                end
                c_full: begin
                    if (w_out_fire) begin
                        r_main_pc   <= r_skid_pc;
                        r_main_data <= r_skid_data;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_one;
                    end
                end
                default: begin
                    r_state     <= c_empty;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_pc    = r_main_pc;
    assign out_data  = r_main_data;
    assign occupancy = r_state;

endmodule
`default_nettype wire
